muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM; sits beside the main ALU in EX.
- Accepts one M-extension op, holds the pipeline via stall for the op's duration, then presents a one-cycle result pulse that the EX stage muxes onto the ALU result path.
- Radix-2 shift-add multiply and restoring divide, one iteration per cycle, with sign pre/post-processing.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX holds a valid M-extension instruction (opcode 0110011, Funct7 0000001)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  WIDTH  rs1 value
- op_b  input  WIDTH  rs2 value
- flush  input  1  branch/jump flush of EX; aborts op in progress
- stall  output  1  freeze PC/IF/ID/EX registers
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  selected product half / quotient / remainder

Behaviour:
- Reset (async, any state): state=IDLE; done=0, busy=0, result=0, internal accumulators cleared; stall=0 (combinational, follows state).
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 -> latch funct3, op_a, op_b; go PREP. start ignored outside IDLE.
- PREP (1 cycle): take absolute values of signed operands (MUL/MULH/DIV/REM: both signed; MULHSU: op_a signed only; U variants: none); record result sign; load iteration counter=WIDTH.
  - Divide by zero (op_b=0, funct3[2]=1): result = all-ones (DIV/DIVU) or op_a (REM/REMU); go DONE.
  - Signed overflow (DIV/REM, op_a=1<<(WIDTH-1), op_b=all-ones): result = op_a (DIV) or 0 (REM); go DONE.
  - Otherwise go CALC.
- CALC (exactly WIDTH cycles): multiply: 2*WIDTH-bit product accumulate, shift multiplier right one bit; divide: restoring step, shift remainder left, subtract divisor, set quotient bit if non-negative. Counter decrements; counter reaching 1 -> FIX.
- FIX (1 cycle): negate product if sign set; quotient negated if operand signs differ; remainder takes dividend sign. Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder. Go DONE.
- DONE (1 cycle): done=1, result valid; go IDLE. result holds value until next DONE.
- stall = (state==IDLE and start and not flush) or state in {PREP, CALC, FIX}. Combinational. Low in DONE so EX advances and captures result that cycle.
- busy = state!=IDLE (registered-state decode).
- Latency, start sampled at cycle T:
  - normal: done at T+WIDTH+3; stall high T..T+WIDTH+2.
  - special case: done at T+2.
- flush in PREP/CALC/FIX: next state IDLE; no done; result unchanged. flush in DONE ignored (done still pulses). flush and start together in IDLE: not accepted.
- Back-to-back: start may be accepted in the cycle after DONE (state IDLE).
- All arithmetic modulo 2^WIDTH, two's complement; no exceptions raised.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD at T -> stall high T..T+34; done at T+35; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done at T+2, result 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+2. REM same operands -> 0.
- flush at T+10 of a DIV -> IDLE at T+11; no done; stall low at T+11; new MUL 3x4 accepted at T+12 -> done at T+47, result 12.
- reset asserted mid-CALC, asynchronously -> outputs 0 and state IDLE immediately; after release, DIVU 9/3 -> result 3 at T+35.

Source files
------------

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative RV32M multiply/divide unit with EX-stage stall
//                    and one-cycle done pulse (radix-2 shift-add / restoring)
// Revision: 1.0
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]         state_q, state_d;
  logic [2:0]         fn_q, fn_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic               w_div0, w_ovf;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quot_mag, w_rem_mag, w_quot, w_rem, w_sel;

  // Signedness: DIV/REM/MUL/MULH both signed, MULHSU rs1 only, U variants none.
  assign w_a_signed = fn_q[2] ? ~fn_q[0] : (fn_q[1:0] != 2'b11);
  assign w_b_signed = fn_q[2] ? ~fn_q[0] : ~fn_q[1];
  assign w_a_neg    = w_a_signed & a_q[WIDTH-1];
  assign w_b_neg    = w_b_signed & b_q[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -a_q : a_q;
  assign w_b_abs    = w_b_neg ? -b_q : b_q;
  assign w_div0     = fn_q[2] & (b_q == '0);
  assign w_ovf      = fn_q[2] & ~fn_q[0] & (a_q == MIN_NEG) & (b_q == '1);

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  assign w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, b_q};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  assign w_prod     = neg_q ? -acc_q : acc_q;
  assign w_quot_mag = acc_q[WIDTH-1:0];
  assign w_rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  assign w_quot     = neg_q ? -w_quot_mag : w_quot_mag;
  assign w_rem      = rneg_q ? -w_rem_mag : w_rem_mag;

  always_comb begin
    w_sel = w_prod[WIDTH-1:0];
    if (fn_q[2])                w_sel = fn_q[1] ? w_rem : w_quot;
    else if (fn_q[1:0] != 2'b00) w_sel = w_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          fn_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          neg_d  = w_a_neg ^ w_b_neg;
          rneg_d = w_a_neg;
          a_d    = w_a_abs;
          b_d    = w_b_abs;
          acc_d  = {{WIDTH{1'b0}}, (fn_q[2] ? w_a_abs : w_b_abs)};
          cnt_d  = CW'(WIDTH);
          if (w_div0) begin
            result_d = fn_q[1] ? a_q : '1;
            state_d  = S_DONE;
          end else if (w_ovf) begin
            result_d = fn_q[1] ? '0 : a_q;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = fn_q[2] ? w_div_next : w_mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = w_sel;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fn_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // DONE drops stall so EX advances and captures the result in that cycle.
  assign stall  = ((state_q == S_IDLE) & start & ~flush) |
                  (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : scoreboard bench for muldiv_sequencer
// Revision: 1.0
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t e_mon;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as_, bs_;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    as_ = a;
    bs_ = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(as_ / bs_);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(as_ % bs_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e_mon = sb_q.pop_front();
        check("result", result, e_mon.res);
        check("done_cycle", cyc, e_mon.cyc);
        last_res = e_mon.res;
      end
    end
  end

  // Drives one op, expects done exactly lat cycles after the start cycle.
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int   t0, lat, bad;
    exp_t e;
    lat = (fn[2] && (b == 0 || (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 35;
    @(posedge clk); #1;
    start = 1'b1; funct3 = fn; op_a = a; op_b = b;
    t0 = cyc;
    e.res = exp;
    e.cyc = t0 + lat;
    sb_q.push_back(e);
    bad = 0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall !== (k < lat)) bad++;
      if (k == 0) begin
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      end
    end
    #1;
    check("stall_window", bad, 0);
    check("done_seen", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          t0;
    logic [2:0]  fn;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_stall", stall, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // flush with start in IDLE is not an acceptance
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    check("start_flush_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", busy, 0);

    // flush mid-CALC of a DIV
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", busy, 1);
    check("flush_stall_before", stall, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", busy, 0);
    check("flush_stall_after", stall, 0);
    check("flush_result_hold", result, last_res);
    run_op(3'd0, 32'd3, 32'd4, 32'd12);

    // asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("calc_busy", busy, 1);
    #1;
    reset = 1'b1;
    #1;
    check("areset_busy", busy, 0);
    check("areset_stall", stall, 0);
    check("areset_done", done, 0);
    check("areset_result", result, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(3'd5, 32'd9, 32'd3, 32'd3);

    // randomized ops, including the special cases
    for (int i = 0; i < 24; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 6 == 1) b = 32'd0;
      if (i % 8 == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(fn, a, b, model(fn, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
